pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 64, width of the payload (e.g. {pc4, instruction}).
REQ-002 Parameter BUBBLE, default all-zero DATA_W value, payload driven when the stage is empty or flushed (NOP encoding).
REQ-003 Parameter CNT_W, default 16, width of the saturating backpressure counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous kill of all held entries (branch taken, exception).
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a live entry.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  DATA_W  head entry payload, or BUBBLE when out_valid=0.
REQ-013 occupancy  output  2  number of live entries, 0..2.
REQ-014 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a main register (drives out_data) and one skid register; state EMPTY (0 entries), ONE (main live), FULL (main and skid live).
REQ-016 in_ready SHALL be decoded from state only: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready or in_valid to in_ready.
REQ-017 Upstream transfer SHALL occur when in_valid & in_ready; downstream transfer when out_valid & out_ready.
REQ-018 EMPTY: transfer in -> main<=in_data, go ONE; otherwise hold.
REQ-019 ONE: in and out transfer -> main<=in_data, stay ONE; in only -> skid<=in_data, go FULL; out only -> main<=BUBBLE, go EMPTY; neither -> hold.
REQ-020 FULL: out transfer -> main<=skid, skid<=BUBBLE, go ONE; otherwise hold; no upstream transfer possible.
REQ-021 Entries SHALL leave in arrival order; no entry duplicated or lost except by flush.
REQ-022 Latency SHALL be one cycle from upstream transfer to out_valid when stage is EMPTY or main is consumed the same cycle.
REQ-023 Full throughput: with out_ready held 1 the stage SHALL accept one entry per cycle indefinitely.
REQ-024 flush SHALL take priority over all transfers: next state EMPTY, main and skid <= BUBBLE, any upstream entry offered that cycle discarded, any downstream transfer that cycle still counts as consumed by downstream.
REQ-025 out_valid SHALL be 1 exactly in ONE and FULL; out_data SHALL equal BUBBLE whenever out_valid=0.
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-027 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, never wrap, and not be cleared by flush.

Reset
REQ-028 On rst assertion, asynchronously: state EMPTY, main and skid = BUBBLE, out_valid=0, occupancy=0, stall_cnt=0, in_ready=1.
REQ-029 Reset mid-operation SHALL discard all entries; first cycle after deassertion behaves as EMPTY.

Verification
REQ-030 Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 on the following consecutive cycles, occupancy never exceeds 1.
REQ-031 Backpressure: send A=0x11, B=0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x11, stall_cnt increments per cycle; raise out_ready -> 0x11 then 0x22, in_ready=1 after first pop.
REQ-032 Flush while FULL with in_valid=1 in_data=0x33 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0; 0x33 never appears.
REQ-033 Simultaneous push/pop in ONE: main=0x44, in_data=0x55, out_ready=1 -> 0x44 consumed, next out_data=0x55, occupancy=1.
REQ-034 Saturation with CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3.
REQ-035 Async reset asserted mid-cycle while FULL -> outputs reach REQ-028 values before next clock edge; entries lost.

Source files
------------

// File: rtl/pipe_skid_if.sv
// pipe_skid_if: valid/ready handshake bundle for the upstream and downstream sides of a pipeline stage
interface pipe_skid_if #(parameter int DATA_W = 64);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid pipeline stage with state-only in_ready and stall counter
module pipe_skid_stage #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_skid_if.slave       bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx, skid_q, skid_nx;
  logic              push, pop, stall;
  assign bus.in_ready  = state != FULL;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_data  = main_q;
  assign occupancy     = state == EMPTY ? 2'd0 : state == ONE ? 2'd1 : 2'd2;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign stall         = bus.out_valid & ~bus.out_ready & ~&stall_cnt;
  // State, storage and stall counter; reset empties the stage immediately, flush leaves the counter alone
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= EMPTY;
      main_q    <= BUBBLE;
      skid_q    <= BUBBLE;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      main_q    <= main_nx;
      skid_q    <= skid_nx;
      stall_cnt <= stall_cnt + CNT_W'(stall);
    end
  // Next state and storage; emptied registers go back to BUBBLE so out_data is BUBBLE whenever invalid
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = BUBBLE;
      skid_nx  = BUBBLE;
    end else
      case (state)
        EMPTY: if (push) begin
          main_nx  = bus.in_data;
          state_nx = ONE;
        end
        ONE: if (push) begin
          main_nx  = pop ? bus.in_data : main_q;
          skid_nx  = pop ? skid_q : bus.in_data;
          state_nx = pop ? ONE : FULL;
        end else if (pop) begin
          main_nx  = BUBBLE;
          state_nx = EMPTY;
        end
        FULL: if (pop) begin
          main_nx  = skid_q;
          skid_nx  = BUBBLE;
          state_nx = ONE;
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = BUBBLE;
          skid_nx  = BUBBLE;
        end
      endcase
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: randomized and directed checks of pipe_skid_stage against a queue model
module tb_pipe_skid_stage;
  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] BUBBLE = 64'h0000_0013_dead_0013;
  logic clk = 0, rst = 1, flush = 0;
  logic [1:0] occ, s_occ;
  logic [15:0] stall_cnt;
  logic [1:0] s_stall;
  int n_vec = 0, n_err = 0;
  logic [DATA_W-1:0] q[$];
  int stall_m = 0;
  pipe_skid_if #(.DATA_W(DATA_W)) bus ();
  pipe_skid_if #(.DATA_W(DATA_W)) sbus ();
  pipe_skid_stage #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .occupancy(occ), .stall_cnt(stall_cnt));
  pipe_skid_stage #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .bus(sbus), .occupancy(s_occ), .stall_cnt(s_stall));
  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_data   = bus.in_data;
  assign sbus.out_ready = bus.out_ready;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
    chk("out_data", bus.out_data, n > 0 ? q[0] : BUBBLE);
    chk("in_ready", 64'(bus.in_ready), 64'(n < 2));
    chk("occupancy", 64'(occ), 64'(n));
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_m > 65535 ? 65535 : stall_m));
    chk("sat_stall", 64'(s_stall), 64'(stall_m > 3 ? 3 : stall_m));
  endtask
  task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
    bit ov = q.size() > 0, ir = q.size() < 2;
    bus.in_valid = iv;
    bus.in_data = id;
    bus.out_ready = ordy;
    flush = fl;
    if (ov && !ordy) stall_m++;
    if (fl) q.delete();
    else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && ir) q.push_back(id);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    flush = 0;
    rst = 1;
    q.delete();
    stall_m = 0;
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    logic [1:0] sat_exp[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    step(1, 64'haa, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 0, 0);
      chk("sat_seq", 64'(s_stall), 64'(sat_exp[i]));
    end
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 64'(i), 1, 0);
      chk("stream_data", bus.out_data, 64'(i));
      chk("stream_occ", 64'(occ), 64'd1);
    end
    step(0, '0, 1, 0);
    step(1, 64'h11, 0, 0);
    step(1, 64'h22, 0, 0);
    chk("bp_occ", 64'(occ), 64'd2);
    chk("bp_head", bus.out_data, 64'h11);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("bp_second", bus.out_data, 64'h22);
    chk("bp_ready", 64'(bus.in_ready), 64'd1);
    step(0, '0, 1, 0);
    step(1, 64'h01, 0, 0);
    step(1, 64'h02, 0, 0);
    step(1, 64'h33, 0, 1);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_data", bus.out_data, BUBBLE);
    step(0, '0, 1, 0);
    chk("flush_no33", 64'(bus.out_valid), 64'd0);
    step(1, 64'h44, 0, 0);
    step(1, 64'h55, 1, 0);
    chk("pp_data", bus.out_data, 64'h55);
    chk("pp_occ", 64'(occ), 64'd1);
    step(0, '0, 1, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0));
    step(1, 64'h66, 0, 0);
    step(1, 64'h77, 0, 0);
    chk("pre_rst_occ", 64'(occ), 64'd2);
    #2 rst = 1;
    q.delete();
    stall_m = 0;
    #1;
    check_all();
    @(negedge clk);
    rst = 0;
    step(1, 64'h88, 1, 0);
    chk("post_rst_data", bus.out_data, 64'h88);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
